// File: rtl/tsp_pkg.sv
// Shared TSP slice definitions: vector geometry, stream ids and small helpers
// used by the SRF slice and the ICU dispatcher.
package tsp_pkg;

    localparam int unsigned NUM_STREAM_ID       = 5;
    localparam int unsigned NUM_STREAMS         = 32;
    localparam int unsigned MIN_VEC_LENGTH      = 16;
    localparam int unsigned NUM_TILES_PER_SLICE = 20;

    typedef logic [MIN_VEC_LENGTH-1:0] lane_t;
    typedef logic [NUM_STREAM_ID-1:0]  stream_id_t;
    typedef lane_t                     vec_t [0:NUM_TILES_PER_SLICE-1];

    // A stream id can name more streams than are implemented; this tells
    // whether the id addresses real storage.
    function automatic logic stream_in_range(input stream_id_t s);
        int unsigned v;
        v = 32'(s);
        return (v < NUM_STREAMS);
    endfunction

endpackage

// File: rtl/srf_write_arbiter.sv
// SRF write arbiter: merges the mem (load) and vxm (result) write ports into
// a single array write per cycle using a one-entry hold buffer for loads that
// collide with a VXM write. Also exposes the hold/accept view for read bypass.
module srf_write_arbiter
    import tsp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mem_wr_en,
    input  stream_id_t i_mem_wr_stream,
    input  vec_t       i_mem_wr_data,
    input  logic       i_vxm_wr_en,
    input  stream_id_t i_vxm_wr_stream,
    input  vec_t       i_vxm_wr_data,
    output logic       o_mem_wr_ready,
    output logic       o_mem_accept,
    output logic       o_hold_valid,
    output stream_id_t o_hold_stream,
    output vec_t       o_hold_data,
    output logic       o_commit_en,
    output stream_id_t o_commit_stream,
    output vec_t       o_commit_data
);

    logic       r_hold_valid;
    stream_id_t r_hold_stream;
    vec_t       r_hold_data;
    logic       w_mem_accept;

    // Ready depends only on the hold state, never on the request itself.
    assign o_mem_wr_ready = !r_hold_valid;
    assign w_mem_accept   = i_mem_wr_en && !r_hold_valid;
    assign o_mem_accept   = w_mem_accept;
    assign o_hold_valid   = r_hold_valid;
    assign o_hold_stream  = r_hold_stream;
    assign o_hold_data    = r_hold_data;

    // Hold buffer: parks a load that loses to a VXM write, drains it in the
    // next VXM-free cycle, and drops it when VXM overwrites the same stream.
    // Out-of-range loads are consumed without ever occupying the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
        end else if (i_vxm_wr_en) begin
            if (r_hold_valid && (r_hold_stream == i_vxm_wr_stream)) begin
                r_hold_valid <= 1'b0;
            end else if (w_mem_accept && stream_in_range(i_mem_wr_stream)) begin
                r_hold_valid  <= 1'b1;
                r_hold_stream <= i_mem_wr_stream;
                r_hold_data   <= i_mem_wr_data;
            end else begin
                r_hold_valid <= r_hold_valid;
            end
        end else begin
            r_hold_valid <= 1'b0;
        end
    end

    // Commit mux: VXM first, then the parked load, then a direct load.
    always_comb begin
        o_commit_en     = 1'b0;
        o_commit_stream = i_vxm_wr_stream;
        o_commit_data   = i_vxm_wr_data;
        if (i_vxm_wr_en) begin
            o_commit_en = stream_in_range(i_vxm_wr_stream);
        end else if (r_hold_valid) begin
            o_commit_en     = stream_in_range(r_hold_stream);
            o_commit_stream = r_hold_stream;
            o_commit_data   = r_hold_data;
        end else if (w_mem_accept) begin
            o_commit_en     = stream_in_range(i_mem_wr_stream);
            o_commit_stream = i_mem_wr_stream;
            o_commit_data   = i_mem_wr_data;
        end else begin
            o_commit_en = 1'b0;
        end
    end

endmodule

// File: rtl/srf_stream_regfile.sv
// Stream Register File slice: vector storage with per-stream valid bits,
// dual-source reads with one-cycle latency and write-first bypass from every
// in-flight write source (vxm, hold buffer, accepted load).
module srf_stream_regfile
    import tsp_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [NUM_STREAM_ID-1:0]  rd_src1,
    input  logic [NUM_STREAM_ID-1:0]  rd_src2,
    output logic [MIN_VEC_LENGTH-1:0] rd_data1 [0:NUM_TILES_PER_SLICE-1],
    output logic [MIN_VEC_LENGTH-1:0] rd_data2 [0:NUM_TILES_PER_SLICE-1],
    output logic                      rd_valid,
    output logic                      rd_err,
    input  logic                      mem_wr_en,
    output logic                      mem_wr_ready,
    input  logic [NUM_STREAM_ID-1:0]  mem_wr_stream,
    input  logic [MIN_VEC_LENGTH-1:0] mem_wr_data [0:NUM_TILES_PER_SLICE-1],
    input  logic                      vxm_wr_en,
    input  logic [NUM_STREAM_ID-1:0]  vxm_wr_stream,
    input  logic [MIN_VEC_LENGTH-1:0] vxm_wr_data [0:NUM_TILES_PER_SLICE-1]
);

    vec_t                   r_mem [0:NUM_STREAMS-1];
    logic [NUM_STREAMS-1:0] r_valid;
    vec_t                   r_rd_data1;
    vec_t                   r_rd_data2;
    logic                   r_rd_valid;
    logic                   r_rd_err;

    logic       w_mem_accept;
    logic       w_hold_valid;
    stream_id_t w_hold_stream;
    vec_t       w_hold_data;
    logic       w_commit_en;
    stream_id_t w_commit_stream;
    vec_t       w_commit_data;

    stream_id_t w_src  [0:1];
    vec_t       w_rdat [0:1];
    logic [1:0] w_rerr;

    srf_write_arbiter u_arb (
        .clk             (clk),
        .rst             (rst),
        .i_mem_wr_en     (mem_wr_en),
        .i_mem_wr_stream (mem_wr_stream),
        .i_mem_wr_data   (mem_wr_data),
        .i_vxm_wr_en     (vxm_wr_en),
        .i_vxm_wr_stream (vxm_wr_stream),
        .i_vxm_wr_data   (vxm_wr_data),
        .o_mem_wr_ready  (mem_wr_ready),
        .o_mem_accept    (w_mem_accept),
        .o_hold_valid    (w_hold_valid),
        .o_hold_stream   (w_hold_stream),
        .o_hold_data     (w_hold_data),
        .o_commit_en     (w_commit_en),
        .o_commit_stream (w_commit_stream),
        .o_commit_data   (w_commit_data)
    );

    // Vector storage; deliberately not reset, the valid bitmap guards reads.
    always_ff @(posedge clk) begin
        if (w_commit_en) begin
            r_mem[w_commit_stream] <= w_commit_data;
        end
    end

    // Valid bitmap: set on every committed write, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= {NUM_STREAMS{1'b0}};
        end else if (w_commit_en) begin
            r_valid[w_commit_stream] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Read lookup per source, newest data first; unwritten or out-of-range
    // streams return a zero vector and flag an error.
    always_comb begin
        w_src[0] = rd_src1;
        w_src[1] = rd_src2;
        for (int p = 0; p < 2; p++) begin
            w_rerr[p] = 1'b0;
            w_rdat[p] = '{default: {MIN_VEC_LENGTH{1'b0}}};
            if (!stream_in_range(w_src[p])) begin
                w_rerr[p] = 1'b1;
            end else if (vxm_wr_en && (vxm_wr_stream == w_src[p])) begin
                w_rdat[p] = vxm_wr_data;
            end else if (w_hold_valid && (w_hold_stream == w_src[p])) begin
                w_rdat[p] = w_hold_data;
            end else if (w_mem_accept && (mem_wr_stream == w_src[p])) begin
                w_rdat[p] = mem_wr_data;
            end else if (r_valid[w_src[p]]) begin
                w_rdat[p] = r_mem[w_src[p]];
            end else begin
                w_rerr[p] = 1'b1;
            end
        end
    end

    // Read response register: one-cycle valid pulse, data held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data1 <= '{default: {MIN_VEC_LENGTH{1'b0}}};
            r_rd_data2 <= '{default: {MIN_VEC_LENGTH{1'b0}}};
        end else if (rd_en) begin
            r_rd_valid <= 1'b1;
            r_rd_err   <= |w_rerr;
            r_rd_data1 <= w_rdat[0];
            r_rd_data2 <= w_rdat[1];
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;

endmodule
